// File: rtl/frame_pix_packer.sv
// rtl/frame_pix_packer.sv - packs PIX_PER_WORD pixels per word, one write strobe per word, one buffer fill per frame
// Optional PACK_MSB_FIRST_EN: pixel 0 of each word goes to the most-significant lane.
module frame_pix_packer #(
   parameter int PIX_WIDTH    = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 3,
   parameter int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pix_valid,
   input  logic                  pix_sof,
   input  logic [PIX_WIDTH-1:0]  pix_data,
   output logic                  pix_ready,
   output logic                  wr_en_out_l,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done,
   output logic                  sof_err
);

   localparam int LANE_W = (PIX_PER_WORD > 2) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

   localparam logic [1:0] WAIT_SOF = 2'd0;
   localparam logic [1:0] PACK     = 2'd1;
   localparam logic [1:0] DONE     = 2'd2;

   logic [1:0]            state;
   logic [LANE_W-1:0]     lane_cnt;
   logic [ADDR_WIDTH-1:0] word_cnt;
   logic [DATA_WIDTH-1:0] pack_word;
   logic [DATA_WIDTH-1:0] word_next;
   logic [LANE_W-1:0]     wr_lane;
   logic [LANE_W-1:0]     phys_lane;
   logic                  accept;

   assign accept  = pix_valid & pix_ready;
   // A start-of-frame pixel always restarts the word in lane 0
   assign wr_lane = pix_sof ? '0 : lane_cnt;

`ifdef PACK_MSB_FIRST_EN
   assign phys_lane = LAST_LANE - wr_lane;
`else
   assign phys_lane = wr_lane;
`endif

   always_comb begin
      word_next = pack_word;
      for (int k = 0; k < PIX_PER_WORD; k++) begin
         if (phys_lane == LANE_W'(k)) begin
            word_next[k*PIX_WIDTH +: PIX_WIDTH] = pix_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_SOF;
         lane_cnt    <= '0;
         word_cnt    <= '0;
         pack_word   <= '0;
         pix_ready   <= 1'b0;
         wr_en_out_l <= 1'b1;
         data_out    <= '0;
         frame_done  <= 1'b0;
         sof_err     <= 1'b0;
      end else begin
         wr_en_out_l <= 1'b1;
         frame_done  <= 1'b0;
         pix_ready   <= 1'b1;
         case (state)
            WAIT_SOF: begin
               if (accept && pix_sof) begin
                  pack_word <= word_next;
                  lane_cnt  <= LANE_W'(1);
                  word_cnt  <= '0;
                  state     <= PACK;
               end
            end
            PACK: begin
               if (accept) begin
                  if (pix_sof) begin
                     // Partial word is dropped; already-strobed words stay written
                     sof_err   <= 1'b1;
                     pack_word <= word_next;
                     lane_cnt  <= LANE_W'(1);
                     word_cnt  <= '0;
                  end else if (lane_cnt == LAST_LANE) begin
                     data_out    <= word_next;
                     wr_en_out_l <= 1'b0;
                     lane_cnt    <= '0;
                     word_cnt    <= word_cnt + 1'b1;
                     if (word_cnt == '1) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        pix_ready  <= 1'b0;
                     end
                  end else begin
                     pack_word <= word_next;
                     lane_cnt  <= lane_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= WAIT_SOF;
            end
            default: begin
               state <= WAIT_SOF;
            end
         endcase
      end
   end

endmodule
